// File: rtl/delay_line_ctrl.sv
// Circular-buffer controller for a single-port WRITE_FIRST delay memory: per accepted
// sample it reads the entry DELAY samples old, then overwrites the current slot.
module delay_line_ctrl #(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic signed [DATA_W-1:0] sample_in_i,
  input  logic                     sample_stb_i,
  input  logic        [ADDR_W-1:0] delay_i,
  output logic                     ready_o,
  output logic signed [DATA_W-1:0] out_sample_o,
  output logic                     out_valid_o,
  output logic                     overrun_o,
  output logic        [ADDR_W-1:0] mem_addr_o,
  output logic signed [DATA_W-1:0] mem_di_o,
  input  logic signed [DATA_W-1:0] mem_do_i,
  output logic                     mem_we_o
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_RD    = 2'd2;
  localparam logic [1:0] S_WR    = 2'd3;

  logic        [1:0]        state_q, state_d;
  logic        [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic        [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic signed [DATA_W-1:0] smp_q, smp_d;
  logic        [ADDR_W-1:0] dly_q, dly_d;
  logic        [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic signed [DATA_W-1:0] mem_di_q, mem_di_d;
  logic                     mem_we_q, mem_we_d;
  logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
  logic                     out_valid_q, out_valid_d;
  logic                     ready_q, ready_d;
  logic                     overrun_q, overrun_d;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    smp_d        = smp_q;
    dly_d        = dly_q;
    mem_addr_d   = mem_addr_q;
    mem_di_d     = mem_di_q;
    mem_we_d     = mem_we_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    ready_d      = ready_q;
    // READY is high exactly while idle, so a strobe seen with READY low is always dropped
    overrun_d    = overrun_q | (sample_stb_i & ~ready_q);

    case (state_q)
      S_CLEAR: begin
        // clr_cnt carries one extra bit so the final address 2**ADDR_W-1 still gets written
        if (clr_cnt_q[ADDR_W]) begin
          mem_we_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = clr_cnt_q[ADDR_W-1:0];
          mem_di_d   = '0;
          clr_cnt_d  = clr_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (sample_stb_i) begin
          smp_d      = sample_in_i;
          dly_d      = delay_i;
          mem_addr_d = wr_ptr_q - delay_i;
          ready_d    = 1'b0;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        mem_addr_d = wr_ptr_q;
        mem_di_d   = smp_q;
        mem_we_d   = 1'b1;
        state_d    = S_WR;
      end
      S_WR: begin
        // read data from the RD address is on mem_do_i during this write cycle
        out_sample_d = (dly_q == '0) ? smp_q : mem_do_i;
        out_valid_d  = 1'b1;
        mem_we_d     = 1'b0;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        ready_d      = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      mem_addr_q   <= '0;
      mem_di_q     <= '0;
      mem_we_q     <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      ready_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      mem_addr_q   <= mem_addr_d;
      mem_di_q     <= mem_di_d;
      mem_we_q     <= mem_we_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
    end
  end

  // Latched sample and delay are pure data: always overwritten before use
  always_ff @(posedge clk_i) begin
    smp_q <= smp_d;
    dly_q <= dly_d;
  end

  assign ready_o      = ready_q;
  assign out_sample_o = out_sample_q;
  assign out_valid_o  = out_valid_q;
  assign overrun_o    = overrun_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_di_o     = mem_di_q;
  assign mem_we_o     = mem_we_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: behavioural WRITE_FIRST memory, reference ring buffer
// and a queue of expected outputs with their strobe cycles.
module tb_delay_line_ctrl;

  localparam int DATA_W = 17;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_stb = 1'b0;
  logic [ADDR_W-1:0] delay = '0;
  logic              ready;
  logic [DATA_W-1:0] out_sample;
  logic              out_valid;
  logic              overrun;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_do;
  logic              mem_we;

  delay_line_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .sample_in_i  (sample_in),
    .sample_stb_i (sample_stb),
    .delay_i      (delay),
    .ready_o      (ready),
    .out_sample_o (out_sample),
    .out_valid_o  (out_valid),
    .overrun_o    (overrun),
    .mem_addr_o   (mem_addr),
    .mem_di_o     (mem_di),
    .mem_do_i     (mem_do),
    .mem_we_o     (mem_we)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_we_rise = 0;
  logic prev_we = 1'b0;

  // Memory model: single port, synchronous read, write-first
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr] <= mem_di;
      mem_do        <= mem_di;
    end else begin
      mem_do <= mem[mem_addr];
    end
  end

  // Reference ring buffer and scoreboard
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [ADDR_W-1:0] ref_ptr;
  logic [DATA_W-1:0] q_val [$];
  int                q_cyc [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we && !prev_we) n_we_rise++;
    prev_we = mem_we;
    if (out_valid) begin
      n_valid++;
      if (q_val.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("out_sample", {15'd0, out_sample}, {15'd0, q_val.pop_front()});
        chk("latency", cyc - q_cyc.pop_front(), 32'd3);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_ptr = '0;
    q_val.delete();
    q_cyc.delete();
  endtask

  // Called at a negedge right after reset release; follows the whole CLEAR sweep
  task automatic check_clear();
    int nwe = 0;
    int err = 0;
    int nz  = 0;
    for (int i = 0; i < DEPTH + 50 && !ready; i++) begin
      @(negedge clk);
      if (mem_we) begin
        if (mem_addr != nwe[ADDR_W-1:0] || mem_di != '0 || nwe >= DEPTH) err++;
        nwe++;
      end
    end
    chk("clr_we_cycles", nwe, DEPTH);
    chk("clr_seq_err", err, 0);
    chk("clr_ready", {31'd0, ready}, 32'd1);
    chk("clr_we_low", {31'd0, mem_we}, 32'd0);
    for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nz++;
    chk("clr_mem_zero", nz, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sample_stb = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_clear();
  endtask

  task automatic send(input logic [DATA_W-1:0] s, input logic [ADDR_W-1:0] d, input int hold);
    int w = 0;
    logic [DATA_W-1:0] e;
    while (!ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    e = (d == '0) ? s : ref_mem[ref_ptr - d];
    ref_mem[ref_ptr] = s;
    ref_ptr = ref_ptr + 1'b1;
    q_val.push_back(e);
    q_cyc.push_back(cyc);
    sample_in  = s;
    delay      = d;
    sample_stb = 1'b1;
    repeat (hold) @(negedge clk);
    sample_stb = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q_val.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("drain", q_val.size(), 0);
  endtask

  initial begin
    int v0, w0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 17'h15555 ^ DATA_W'(i);
    mem_do = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outs", {out_sample, mem_di, overrun}, 32'd0);
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_clear();

    // DELAY=4 ramp at minimum spacing
    for (int k = 1; k <= 12; k++) send(DATA_W'(k), 10'd4, 1);
    drain();

    // Full-depth delay across the pointer wrap
    do_reset();
    for (int k = 1; k <= 1100; k++) send(DATA_W'(k), 10'd1023, 1);
    drain();

    // Bypass; memory still receives the sample
    send(17'h1ABCD, 10'd0, 1);
    send(17'h00001, 10'd0, 1);
    drain();
    repeat (2) @(negedge clk);
    chk("bypass_mem_wr0", {15'd0, mem[ref_ptr - 10'd2]}, 32'h1ABCD);
    chk("bypass_mem_wr1", {15'd0, mem[ref_ptr - 10'd1]}, 32'h00001);
    send(17'h00777, 10'd2, 1);
    drain();

    // Back-to-back strobes: second is dropped
    chk("overrun_clean", {31'd0, overrun}, 32'd0);
    v0 = n_valid;
    w0 = n_we_rise;
    send(17'h0ABCD, 10'd3, 2);
    drain();
    repeat (4) @(negedge clk);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_we_pulses", n_we_rise - w0, 32'd1);
    chk("ovr_valids", n_valid - v0, 32'd1);
    repeat (3) @(negedge clk);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset while the write is in progress
    send(17'h05555, 10'd1, 1);
    @(negedge clk);
    chk("in_wr_we", {31'd0, mem_we}, 32'd1);
    v0 = n_valid;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_outs", {out_sample, mem_di, overrun}, 32'd0);
    chk("mid_rst_addr", {22'd0, mem_addr}, 32'd0);
    q_val.delete();
    q_cyc.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_clear();
    chk("mid_rst_no_valid", n_valid - v0, 32'd0);
    send(17'h01234, 10'd1, 1);
    drain();
    chk("post_rst_out", {15'd0, out_sample}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
